fp_div: RTL and testbench



---
 rtl/fp_div.sv | 193 +++++++++++++++++++
 tb/tb_fp_div.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_div.sv
// ---------------------------------------------------------------------------
// fp_div -- sequential signed fixed-point divider (restoring, 1 bit / clock)
//
// Computes out_data = a / b in Q(fp_width-fp_frac).fp_frac two's complement.
// Magnitudes are divided, the quotient is truncated toward zero, and the sign
// is applied afterwards with saturation to the representable range.
// One operation in flight; fixed latency of fp_width+fp_frac+1 cycles from
// the accept edge to out_valid.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands present on a/b
//   in_ready   block can accept operands (high only in IDLE)
//   a, b       dividend / divisor, signed fixed point
//   out_valid  result present (held until out_ready)
//   out_ready  consumer accepts result
//   out_data   quotient, signed fixed point (held in IDLE)
//   out_ovf    result saturated due to overflow
//   out_dz     divisor was zero
// ---------------------------------------------------------------------------
module fp_div #(
  parameter int fp_width = 16,
  parameter int fp_frac  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [fp_width-1:0] a,
  input  logic [fp_width-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [fp_width-1:0] out_data,
  output logic                out_ovf,
  output logic                out_dz
);

  localparam int W  = fp_width;
  localparam int F  = fp_frac;
  localparam int N  = W + F;
  localparam int CW = $clog2(N);

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [W-1:0]  POS_SAT  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  NEG_SAT  = {1'b1, {(W-1){1'b0}}};
  // Largest quotient magnitudes that still fit for each result sign.
  localparam logic [N-1:0]  POS_MAX  = (N'(1) << (W - 1)) - N'(1);
  localparam logic [N-1:0]  NEG_MAX  = (N'(1) << (W - 1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [N-1:0]  dividend_reg;
  logic [W-1:0]  divisor_reg;
  logic [W-1:0]  rem_reg;
  logic [N-1:0]  quot_reg;
  logic [CW-1:0] cnt_reg;
  logic          sign_reg;
  logic          dz_reg;
  logic          a_neg_reg;
  logic [W-1:0]  out_data_reg;
  logic          out_ovf_reg;
  logic          out_dz_reg;

  // Combinational datapath helpers.
  logic [W-1:0]  abs_a, abs_b;
  logic [W:0]    rem_shift;
  logic [W-1:0]  rem_diff;
  logic          rem_ge;
  logic [W-1:0]  fin_data;
  logic          fin_ovf;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (in_valid)              state_next = S_CALC;
      S_CALC:  if (cnt_reg == CNT_LAST)   state_next = S_FIN;
      S_FIN:                              state_next = S_DONE;
      S_DONE:  if (out_ready)             state_next = S_IDLE;
      default:                            state_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  // Decoded from the state register only, so in_ready never depends on
  // out_ready combinationally.
  always_comb begin
    in_ready  = (state_reg == S_IDLE);
    out_valid = (state_reg == S_DONE);
  end

  assign out_data = out_data_reg;
  assign out_ovf  = out_ovf_reg;
  assign out_dz   = out_dz_reg;

  // ----------------------------------------------------------------- datapath
  always_comb begin
    // |-2^(W-1)| wraps to 2^(W-1), which is exactly right read as unsigned.
    abs_a     = a[W-1] ? (W'(0) - a) : a;
    abs_b     = b[W-1] ? (W'(0) - b) : b;
    rem_shift = {rem_reg, dividend_reg[N-1]};
    rem_ge    = (rem_shift >= {1'b0, divisor_reg});
    // When rem_ge holds the difference is below the divisor, so the low W
    // bits carry the whole result.
    rem_diff  = rem_shift[W-1:0] - divisor_reg;

    fin_data = '0;
    fin_ovf  = 1'b0;
    if (dz_reg) begin
      fin_data = a_neg_reg ? NEG_SAT : POS_SAT;
    end else if (!sign_reg) begin
      if (quot_reg > POS_MAX) begin
        fin_data = POS_SAT;
        fin_ovf  = 1'b1;
      end else begin
        fin_data = quot_reg[W-1:0];
      end
    end else begin
      if (quot_reg > NEG_MAX) begin
        fin_data = NEG_SAT;
        fin_ovf  = 1'b1;
      end else begin
        fin_data = W'(0) - quot_reg[W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend_reg <= '0;
      divisor_reg  <= '0;
      rem_reg      <= '0;
      quot_reg     <= '0;
      cnt_reg      <= '0;
      sign_reg     <= 1'b0;
      dz_reg       <= 1'b0;
      a_neg_reg    <= 1'b0;
      out_data_reg <= '0;
      out_ovf_reg  <= 1'b0;
      out_dz_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            dividend_reg <= N'(abs_a) << F;
            divisor_reg  <= abs_b;
            sign_reg     <= a[W-1] ^ b[W-1];
            dz_reg       <= (b == '0);
            a_neg_reg    <= a[W-1];
            rem_reg      <= '0;
            quot_reg     <= '0;
            cnt_reg      <= '0;
          end
        end
        S_CALC: begin
          dividend_reg <= dividend_reg << 1;
          cnt_reg      <= cnt_reg + CW'(1);
          if (rem_ge) begin
            rem_reg  <= rem_diff;
            quot_reg <= {quot_reg[N-2:0], 1'b1};
          end else begin
            rem_reg  <= rem_shift[W-1:0];
            quot_reg <= {quot_reg[N-2:0], 1'b0};
          end
        end
        S_FIN: begin
          out_data_reg <= fin_data;
          out_ovf_reg  <= fin_ovf;
          out_dz_reg   <= dz_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// ---------------------------------------------------------------------------
// tb_fp_div -- self-checking bench for fp_div (W=16, F=8).
// Directed vectors with literal expectations, randomized operations against
// an arithmetic reference model, backpressure, and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_fp_div;

  localparam int W       = 16;
  localparam int F       = 8;
  localparam int LATENCY = W + F + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_ovf;
  logic          out_dz;

  int n_checks;
  int n_fail;

  fp_div #(.fp_width(W), .fp_frac(F)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_dz    (out_dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact rational a*2^F / b, truncated toward zero by integer
  // division, then clamped to the signed W-bit range.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                output logic [W-1:0] d, output logic o, output logic z);
    longint num, q;
    z = (mb == '0);
    o = 1'b0;
    if (z) begin
      d = ($signed(ma) >= 0) ? 16'h7FFF : 16'h8000;
    end else begin
      num = longint'($signed(ma)) * (longint'(1) << F);
      q   = num / longint'($signed(mb));
      if (q > 32767) begin
        d = 16'h7FFF; o = 1'b1;
      end else if (q < -32768) begin
        d = 16'h8000; o = 1'b1;
      end else begin
        d = W'(q);
      end
    end
  endfunction

  // Issue one operation and check latency, result and handshake.
  // bp_cycles > 0 holds out_ready low that many cycles after out_valid.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [W-1:0] exp_d, input logic exp_o, input logic exp_z,
                        input int bp_cycles);
    int lat;
    logic [W-1:0] held;
    check_eq("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_v;
    out_ready = (bp_cycles == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      // in_valid pulses while busy must be ignored
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
      if (!out_valid) check_eq("in_ready_busy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check_eq("latency", 32'(lat), 32'(LATENCY));
    check_eq("out_data", 32'(out_data), 32'(exp_d));
    check_eq("out_ovf", 32'(out_ovf), 32'(exp_o));
    check_eq("out_dz", 32'(out_dz), 32'(exp_z));
    $display("op a=%h b=%h -> data=%h ovf=%0d dz=%0d lat=%0d", ta, tb_v, out_data, out_ovf, out_dz, lat);
    held = out_data;
    for (int i = 0; i < bp_cycles; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk); #1;
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_data", 32'(out_data), 32'(exp_d));
      check_eq("bp_ovf", 32'(out_ovf), 32'(exp_o));
      check_eq("bp_dz", 32'(out_dz), 32'(exp_z));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("valid_drop", 32'(out_valid), 32'd0);
    check_eq("in_ready_after", 32'(in_ready), 32'd1);
    check_eq("data_retained", 32'(out_data), 32'(held));
  endtask

  task automatic run_model_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int bp);
    logic [W-1:0] d;
    logic o, z;
    model(ta, tb_v, d, o, z);
    run_op(ta, tb_v, d, o, z, bp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int stale;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_out_ovf", 32'(out_ovf), 32'd0);
    check_eq("rst_out_dz", 32'(out_dz), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with literal expectations.
    run_op(16'h0180, 16'h0180, 16'h0100, 1'b0, 1'b0, 0);
    run_op(16'h0300, 16'hFE00, 16'hFE80, 1'b0, 1'b0, 0);
    run_op(16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 0);
    run_op(16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0, 0);
    run_op(16'h6400, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 0);
    run_op(16'h8000, 16'h0080, 16'h8000, 1'b1, 1'b0, 0);
    run_op(16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, 0);
    run_op(16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1, 0);
    run_op(16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 0);

    // Backpressure, then an immediate back-to-back operation.
    run_op(16'h0300, 16'hFE00, 16'hFE80, 1'b0, 1'b0, 10);
    run_op(16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 0);

    // Asynchronous reset in the middle of CALC.
    in_valid = 1'b1;
    a = 16'h0180;
    b = 16'h0080;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_out_data", 32'(out_data), 32'd0);
    check_eq("midrst_out_ovf", 32'(out_ovf), 32'd0);
    check_eq("midrst_out_dz", 32'(out_dz), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check_eq("no_stale_valid", 32'(stale), 32'd0);
    $display("reset mid-CALC: stale valid cycles=%0d", stale);
    run_op(16'h0180, 16'h0180, 16'h0100, 1'b0, 1'b0, 0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 255));
        2:       rb = W'(-$signed(32'($urandom_range(1, 255))));
        default: rb = W'($urandom);
      endcase
      run_model_op(ra, rb, (i % 7 == 3) ? int'($urandom_range(1, 5)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
